branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//   Direct-mapped BTB + 2-bit saturating-counter BHT for the RV32I pipeline.
//   Replaces static "predict not-taken" fetch: IF looks up pc_if and redirects
//   on a predicted-taken hit; EX (after BranchDecision resolves br) trains the
//   table and counts mispredictions for perf reporting.
// PARAMETERS
//   IDX_W    6   index bits; ENTRIES = 2**IDX_W; index = pc[IDX_W+1:2]
//   CNT_W   32   width of perf counters br_cnt / miss_cnt
// PORTS
//   clk              in   1      core clock, all state updates on rising edge
//   rst              in   1      synchronous, active-high reset
//   pc_if            in   32     IF-stage PC for lookup
//   pred_taken       out  1      1 = redirect fetch to pred_target
//   pred_target      out  32     predicted target (0 when pred_taken=0)
//   upd_valid        in   1      EX-stage conditional branch resolves this cycle
//   upd_pc           in   32     PC of resolving branch
//   upd_taken        in   1      actual outcome (BranchDecision br)
//   upd_target       in   32     actual computed target
//   upd_pred_taken   in   1      prediction made for this branch in IF (piped)
//   upd_pred_target  in   32     target predicted in IF (piped)
//   mispredict       out  1      comb.: resolving branch was mispredicted
//   br_cnt           out  CNT_W  branches resolved since reset
//   miss_cnt         out  CNT_W  mispredictions since reset
// BEHAVIOUR
//   Entry = {valid, tag[31:IDX_W+2], target[31:0], ctr[1:0]}.
//   Lookup: combinational, 0-cycle; hit = valid && tag==pc_if[31:IDX_W+2].
//     pred_taken = hit && ctr[1]; pred_target = pred_taken ? target : 32'h0.
//   Update (rising edge, upd_valid && !rst), idx/tag from upd_pc:
//     hit,  taken    : ctr = sat_inc(ctr) (max 2'b11); target <= upd_target
//     hit,  !taken   : ctr = sat_dec(ctr) (min 2'b00); target unchanged
//     miss, taken    : allocate/evict: valid=1, tag, target, ctr=2'b10
//     miss, !taken   : no change (no allocation of never-taken branches)
//   mispredict = upd_valid && (upd_pred_taken != upd_taken ||
//                (upd_taken && upd_pred_target != upd_target)); 0 when !upd_valid.
//   Counters: on upd_valid edge br_cnt+=1; if mispredict miss_cnt+=1;
//     both saturate at all-ones (no wrap).
//   Same-cycle lookup and update of same index: lookup returns PRE-update
//     state; new state visible from next cycle.
//   Reset: at edge with rst=1 all valid=0, ctr=2'b01, tag/target=0,
//     br_cnt=miss_cnt=0; upd_valid ignored that cycle. Hence after reset
//     pred_taken=0, pred_target=0. Reset mid-run discards all history.
//   pc_if/upd_pc bits [1:0] ignored. Aliasing PCs (same idx, diff tag) evict.
//   Pipeline owns flush: upd_valid must only assert for committed-path branches.
// TESTING
//   1 rst, then pc_if=0x100 -> pred_taken=0, pred_target=0, br_cnt=miss_cnt=0.
//   2 upd pc=0x100 taken tgt=0x80 pred_taken=0 -> next cycle pc_if=0x100:
//     pred_taken=1, pred_target=0x80; mispredict=1 at update; miss_cnt=1.
//   3 0x100 not-taken x1 -> ctr 10->01, pred_taken=0; not-taken x3 more ->
//     ctr stays 00; then taken x2 -> ctr 10, pred_taken=1 (saturation both ends).
//   4 alias: pc 0x100 allocated, update taken pc=0x100+4*2**IDX_W tgt=0x200 ->
//     lookup 0x100 misses (pred_taken=0), alias PC predicts 0x200.
//   5 same-cycle: lookup 0x100 while first taken update of 0x100 ->
//     pred_taken=0 that cycle, 1 next cycle; direction-right/target-wrong
//     (pred 0x80, actual 0x90) -> mispredict=1, target rewritten to 0x90.
//   6 rst asserted with upd_valid=1 after training -> all lookups miss,
//     counters 0; miss_cnt preset near all-ones (small CNT_W=4) saturates at 15.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// IF looks up pc_if combinationally and redirects on a predicted-taken hit.
// EX trains the table via upd_* and counts resolved branches and mispredictions.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   pc_if             : fetch PC to look up
//   pred_taken/target : lookup result (target is 0 when not predicted taken)
//   upd_*             : resolved branch from EX (pc, outcome, target, IF prediction)
//   mispredict        : the resolving branch was mispredicted (combinational)
//   br_cnt, miss_cnt  : saturating counters of resolved branches and mispredictions
module branch_target_predictor #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_if,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] vld;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [31:0]        tgts [ENTRIES];
  logic [1:0]         ctrs [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr;

  // Instruction alignment bits never take part in indexing or tagging.
  logic unused_lsbs;
  assign unused_lsbs = ^{pc_if[1:0], upd_pc[1:0]};

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[31:IDX_W+2];
  assign lk_hit = vld[lk_idx] && (tags[lk_idx] == lk_tag);

  // Reads the registered table, so a same-cycle update is seen next cycle.
  assign pred_taken  = lk_hit && ctrs[lk_idx][1];
  assign pred_target = pred_taken ? tgts[lk_idx] : 32'h0;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = vld[up_idx] && (tags[up_idx] == up_tag);
  assign up_ctr = ctrs[up_idx];

  // A wrong target only matters when the branch was actually taken.
  assign mispredict = upd_valid &&
    ((upd_pred_taken != upd_taken) ||
     (upd_taken && (upd_pred_target != upd_target)));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i] <= '0;
        tgts[i] <= '0;
        ctrs[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (br_cnt != '1)
        br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);
      if (up_hit) begin
        if (upd_taken) begin
          if (up_ctr != 2'b11)
            ctrs[up_idx] <= up_ctr + 2'b01;
          tgts[up_idx] <= upd_target;
        end else if (up_ctr != 2'b00) begin
          ctrs[up_idx] <= up_ctr - 2'b01;
        end
      end else if (upd_taken) begin
        // Only taken branches earn an entry; this evicts any alias.
        vld[up_idx]  <= 1'b1;
        tags[up_idx] <= up_tag;
        tgts[up_idx] <= upd_target;
        ctrs[up_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed table-driven bench for branch_target_predictor.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        pred_taken, pred_taken4;
  logic [31:0] pred_target, pred_target4;
  logic        mispredict, mispredict4;
  logic [31:0] br_cnt, miss_cnt;
  logic [3:0]  br_cnt4, miss_cnt4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_target_predictor #(.IDX_W(6), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict4),
    .br_cnt(br_cnt4), .miss_cnt(miss_cnt4)
  );

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg;
    logic        upt;
    logic [31:0] uptg;
    logic        ept;
    logic [31:0] etg;
    logic        emp;
    int          ebr;
    int          emiss;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic [31:0] pc, logic uv, logic [31:0] upc,
    logic ut, logic [31:0] utg, logic upt,
    logic [31:0] uptg, logic ept, logic [31:0] etg,
    logic emp, int ebr, int emiss);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc;
    v.ut = ut; v.utg = utg; v.upt = upt;
    v.uptg = uptg; v.ept = ept; v.etg = etg;
    v.emp = emp; v.ebr = ebr; v.emiss = emiss;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [31:0] pc, logic uv,
                       logic [31:0] upc, logic ut,
                       logic [31:0] utg, logic upt,
                       logic [31:0] uptg);
    pc_if = pc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utg;
    upd_pred_taken = upt; upd_pred_target = uptg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(string name, logic [31:0] pc,
                      logic ept, logic [31:0] etg);
    pc_if = pc;
    #1;
    chk({name, ".pt"}, 32'(pred_taken), 32'(ept));
    chk({name, ".tgt"}, pred_target, etg);
  endtask

  initial begin
    // pc, uv, upc, ut, utg, upt, uptg | pt, tgt, mp, br, miss
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 0,'h0,0,0,0));
    vt.push_back(mk('h100,1,'h100,1,'h80,0,'h0, 0,'h0,1,0,0));
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 1,'h80,0,1,1));
    vt.push_back(mk('h100,1,'h100,0,'h0,1,'h80, 1,'h80,1,1,1));
    vt.push_back(mk('h100,1,'h100,0,'h0,0,'h0, 0,'h0,0,2,2));
    vt.push_back(mk('h100,1,'h100,0,'h0,0,'h0, 0,'h0,0,3,2));
    vt.push_back(mk('h100,1,'h100,0,'h0,0,'h0, 0,'h0,0,4,2));
    vt.push_back(mk('h100,1,'h100,1,'h80,0,'h0, 0,'h0,1,5,2));
    vt.push_back(mk('h100,1,'h100,1,'h80,0,'h0, 0,'h0,1,6,3));
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 1,'h80,0,7,4));
    vt.push_back(mk('h100,1,'h100,1,'h90,1,'h80, 1,'h80,1,7,4));
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 1,'h90,0,8,5));
    vt.push_back(mk('h100,1,'h100,1,'h90,1,'h90, 1,'h90,0,8,5));
    vt.push_back(mk('h100,1,'h100,0,'h0,1,'h90, 1,'h90,1,9,5));
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 1,'h90,0,10,6));
    vt.push_back(mk('h100,0,'h100,1,'h44,0,'h0, 1,'h90,0,10,6));
    vt.push_back(mk('h200,1,'h200,1,'h200,0,'h0, 0,'h0,1,10,6));
    vt.push_back(mk('h100,0,'h0,0,'h0,0,'h0, 0,'h0,0,11,7));
    vt.push_back(mk('h200,0,'h0,0,'h0,0,'h0, 1,'h200,0,11,7));
    vt.push_back(mk('h203,0,'h0,0,'h0,0,'h0, 1,'h200,0,11,7));
    vt.push_back(mk('h304,1,'h304,0,'h0,0,'h0, 0,'h0,0,11,7));
    vt.push_back(mk('h304,0,'h0,0,'h0,0,'h0, 0,'h0,0,12,7));
    vt.push_back(mk('h200,1,'h304,1,'h1000,0,'h0, 1,'h200,1,12,7));
    vt.push_back(mk('h304,0,'h0,0,'h0,0,'h0, 1,'h1000,0,13,8));

    rst = 1'b1;
    drive('h100, 0, 'h0, 0, 'h0, 0, 'h0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vt[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      drive(vt[i].pc, vt[i].uv, vt[i].upc, vt[i].ut,
            vt[i].utg, vt[i].upt, vt[i].uptg);
      #1;
      chk({nm, ".pt"}, 32'(pred_taken), 32'(vt[i].ept));
      chk({nm, ".tgt"}, pred_target, vt[i].etg);
      chk({nm, ".mp"}, 32'(mispredict), 32'(vt[i].emp));
      chk({nm, ".br"}, br_cnt, 32'(vt[i].ebr));
      chk({nm, ".miss"}, miss_cnt, 32'(vt[i].emiss));
      chk({nm, ".br4"}, 32'(br_cnt4), 32'(vt[i].ebr));
      chk({nm, ".miss4"}, 32'(miss_cnt4), 32'(vt[i].emiss));
      tick();
    end

    // Reset with a live update: update must be dropped, history wiped.
    rst = 1'b1;
    drive('h100, 1, 'h100, 1, 'h80, 0, 'h0);
    tick();
    rst = 1'b0;
    drive('h100, 0, 'h0, 0, 'h0, 0, 'h0);
    look("rst.100", 'h100, 0, 'h0);
    look("rst.200", 'h200, 0, 'h0);
    look("rst.304", 'h304, 0, 'h0);
    chk("rst.br", br_cnt, 0);
    chk("rst.miss", miss_cnt, 0);
    chk("rst.br4", 32'(br_cnt4), 0);
    chk("rst.miss4", 32'(miss_cnt4), 0);

    // Twenty mispredicted branches: 4-bit counters stop at 15.
    for (int k = 0; k < 20; k++) begin
      drive('h0, 1, 32'h400 + 32'(k) * 4, 1, 'h800, 0, 'h0);
      tick();
    end
    drive('h0, 0, 'h0, 0, 'h0, 0, 'h0);
    #1;
    chk("sat.br", br_cnt, 20);
    chk("sat.miss", miss_cnt, 20);
    chk("sat.br4", 32'(br_cnt4), 15);
    chk("sat.miss4", 32'(miss_cnt4), 15);
    look("sat.404", 'h404, 1, 'h800);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
